// File: rtl/dram_uart_dumper.sv
// Walks every address of an async-read distributed RAM and sends each byte out as UART 8N1.
// The byte is frozen at LOAD so RAM writes during a frame never disturb the word in flight.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | tx high, waiting for start
// S_LOAD  | one cycle: latch ram_data into the shift register, drop tx
// S_START | start bit (tx low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (tx high); then next address or finish with done
module dram_uart_dumper #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [7:0]        ram_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_t;

  state_t              r_state, r_state_nxt;
  logic [ADDR_W-1:0]   r_addr, r_addr_nxt;
  logic [BAUD_W-1:0]   r_baud, r_baud_nxt;
  logic [2:0]          r_bit, r_bit_nxt;
  logic [7:0]          r_shift, r_shift_nxt;
  logic                r_tx, r_tx_nxt;
  logic                r_busy, r_busy_nxt;
  logic                r_done, r_done_nxt;
  logic                w_baud_end;

  assign w_baud_end = (r_baud == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_addr  <= r_addr_nxt;
      r_baud  <= r_baud_nxt;
      r_bit   <= r_bit_nxt;
      r_shift <= r_shift_nxt;
      r_tx    <= r_tx_nxt;
      r_busy  <= r_busy_nxt;
      r_done  <= r_done_nxt;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_addr_nxt  = r_addr;
    r_baud_nxt  = r_baud;
    r_bit_nxt   = r_bit;
    r_shift_nxt = r_shift;
    r_tx_nxt    = r_tx;
    r_busy_nxt  = r_busy;
    r_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        r_tx_nxt   = 1'b1;
        r_busy_nxt = 1'b0;
        if (start) begin
          r_state_nxt = S_LOAD;
          r_busy_nxt  = 1'b1;
          r_baud_nxt  = '0;
        end
      end
      S_LOAD: begin
        r_shift_nxt = ram_data;
        r_tx_nxt    = 1'b0;
        r_baud_nxt  = '0;
        r_state_nxt = S_START;
      end
      S_START: begin
        if (w_baud_end) begin
          r_baud_nxt  = '0;
          r_bit_nxt   = '0;
          r_tx_nxt    = r_shift[0];
          r_shift_nxt = r_shift >> 1;
          r_state_nxt = S_DATA;
        end else begin
          r_baud_nxt = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          r_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            r_tx_nxt    = 1'b1;
            r_state_nxt = S_STOP;
          end else begin
            r_tx_nxt    = r_shift[0];
            r_shift_nxt = r_shift >> 1;
            r_bit_nxt   = r_bit + 1'b1;
          end
        end else begin
          r_baud_nxt = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          r_baud_nxt = '0;
          // Address only wraps on completion, so a dump never repeats a word.
          if (r_addr == ADDR_LAST) begin
            r_addr_nxt  = '0;
            r_busy_nxt  = 1'b0;
            r_done_nxt  = 1'b1;
            r_state_nxt = S_IDLE;
          end else begin
            r_addr_nxt  = r_addr + 1'b1;
            r_state_nxt = S_LOAD;
          end
        end else begin
          r_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        r_state_nxt = S_IDLE;
      end
    endcase
  end

  assign ram_addr = r_addr;
  assign tx       = r_tx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_dram_uart_dumper.sv
// Bench for dram_uart_dumper: RAM model, UART receiver monitor fed by an expected-byte scoreboard,
// plus directed frame-timing, busy, back-to-back, write-during-frame and mid-frame reset checks.
module tb_dram_uart_dumper;
  localparam int CPB    = 4;
  localparam int ADDR_W = 6;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int WORD_CYC = 1 + 10 * CPB;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              tx;
  logic              busy;
  logic              done;

  logic [7:0] mem [NWORDS];
  logic [7:0] sb [$];
  int n_chk  = 0;
  int n_fail = 0;
  int rx_total = 0;

  assign ram_data = mem[ram_addr];

  dram_uart_dumper #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_dump();
    for (int a = 0; a < NWORDS; a++) sb.push_back(mem[a]);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done && c < 3 * NWORDS * WORD_CYC) begin
      tick();
      c++;
    end
    chk(name, {31'b0, done}, 32'd1);
  endtask

  // UART receiver: samples mid-bit on the falling clock edge.
  initial begin : monitor
    logic       prev_tx;
    logic       rx_active;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic [7:0] exp;
    prev_tx   = 1'b1;
    rx_active = 1'b0;
    rx_cnt    = 0;
    rx_byte   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_active = 1'b0;
        prev_tx   = 1'b1;
      end else begin
        if (!rx_active) begin
          if (prev_tx && !tx) begin
            rx_active = 1'b1;
            rx_cnt    = 0;
          end
        end else begin
          rx_cnt++;
          if (rx_cnt == CPB / 2) chk("rx_start_bit", {31'b0, tx}, 32'd0);
          if (rx_cnt >= CPB + CPB / 2 && rx_cnt <= 8 * CPB + CPB / 2 &&
              ((rx_cnt - CPB - CPB / 2) % CPB) == 0)
            rx_byte[(rx_cnt - CPB - CPB / 2) / CPB] = tx;
          if (rx_cnt == 9 * CPB + CPB / 2) begin
            chk("rx_stop_bit", {31'b0, tx}, 32'd1);
            rx_active = 1'b0;
            rx_total++;
            if (sb.size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL rx_unexpected: got %0h expected no byte", rx_byte);
            end else begin
              exp = sb.pop_front();
              chk("rx_byte", {24'b0, rx_byte}, {24'b0, exp});
            end
          end
        end
        prev_tx = tx;
      end
    end
  end

  initial begin : stim
    int dfirst;
    int dcnt;
    int rx_mark;
    int idx;
    logic [7:0] b0;
    logic exp_tx;
    logic quiet;

    rst_n = 1'b0;
    start = 1'b0;
    for (int a = 0; a < NWORDS; a++) mem[a] = 8'(a) ^ 8'hA5;
    repeat (3) tick();
    chk("reset_outputs", {28'b0, tx, busy, done, 1'b0} | 32'(ram_addr) << 4, 32'h8);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!(tx === 1'b1 && busy === 1'b0 && done === 1'b0 && ram_addr === '0)) quiet = 1'b0;
    end
    chk("idle_after_reset", {31'b0, quiet}, 32'd1);

    // Full dump with ignored start pulses while busy
    push_dump();
    rx_mark = rx_total;
    start = 1'b1;
    tick();
    dfirst = -1;
    dcnt   = 0;
    for (int k = 1; k <= NWORDS * WORD_CYC + 80; k++) begin
      start = (k == 10 || k == 500);
      tick();
      if (done) begin
        dcnt++;
        if (dfirst < 0) dfirst = k;
      end
      if (k == 1) chk("busy_after_start", {31'b0, busy}, 32'd1);
      if (k == NWORDS * WORD_CYC - 1) chk("busy_before_done", {31'b0, busy}, 32'd1);
      if (k == NWORDS * WORD_CYC) chk("busy_at_done", {31'b0, busy}, 32'd0);
    end
    start = 1'b0;
    chk("done_cycle", 32'(dfirst), 32'(NWORDS * WORD_CYC));
    chk("done_pulses", 32'(dcnt), 32'd1);
    chk("dump1_bytes", 32'(rx_total - rx_mark), 32'(NWORDS));
    chk("dump1_sb_empty", 32'(sb.size()), 32'd0);

    // Frame timing on word 0 = 8'h01; start stays high for a back-to-back dump
    mem[0] = 8'h01;
    b0 = 8'h01;
    push_dump();
    start = 1'b1;
    tick();
    for (int k = 1; k <= WORD_CYC; k++) begin
      tick();
      if (k < WORD_CYC) begin
        idx = (k - 1) / CPB;
        if (idx == 0) exp_tx = 1'b0;
        else if (idx == 9) exp_tx = 1'b1;
        else exp_tx = b0[idx - 1];
        chk($sformatf("frame_tx_k%0d", k), {31'b0, tx}, {31'b0, exp_tx});
      end else begin
        chk("addr_after_word0", 32'(ram_addr), 32'd1);
      end
    end
    mem[0] = 8'hA5;
    wait_done("dump2_done");
    push_dump();
    tick();
    chk("b2b_tx_high", {31'b0, tx}, 32'd1);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    tick();
    chk("b2b_tx_fall", {31'b0, tx}, 32'd0);

    // Overwrite word 5 while it is in DATA
    repeat (219) tick();
    chk("addr_word5", 32'(ram_addr), 32'd5);
    mem[5] = 8'h00;
    wait_done("dump3_done");
    chk("dump3_sb_empty", 32'(sb.size()), 32'd0);

    start = 1'b1;
    push_dump();
    tick();
    start = 1'b0;
    wait_done("dump4_done");
    tick();
    chk("dump4_sb_empty", 32'(sb.size()), 32'd0);

    // Reset inside word 0 DATA
    mem[5] = 8'(5) ^ 8'hA5;
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'b0, tx}, 32'd1);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    sb.delete();
    rx_mark = rx_total;
    repeat (3) tick();
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!(tx === 1'b1 && busy === 1'b0)) quiet = 1'b0;
    end
    chk("quiet_after_mid_reset", {31'b0, quiet}, 32'd1);
    chk("no_rx_after_reset", 32'(rx_total - rx_mark), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dram_uart_dumper.md
Name: dram_uart_dumper

Overview:
- Read-back counterpart to the switch-driven distributed-RAM write tests.
- On a start pulse, the block walks every address of a shared-address distributed RAM (RAM64M8-style, 8 bits wide, asynchronous read).
- It latches each 8-bit word and transmits it over a UART TX line as 8N1, address 0 first.
- Sits between the DRAM primitive's read ports and the board tx pin, so on-board contents can be checked from a host.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); legal range >= 2.
- ADDR_W, 6, RAM address width; dump length is 2**ADDR_W words.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a full dump; sampled only in IDLE.
- ram_addr  output  ADDR_W  read address driven to all RAM read ports (ADDRA..ADDRH).
- ram_data  input  8  combinational RAM read data {DOH..DOA}, valid one cycle after ram_addr changes.
- tx  output  1  UART serial out, idle high.
- busy  output  1  high from the cycle after start is accepted until dump completion.
- done  output  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): state=IDLE, tx=1, busy=0, done=0, ram_addr=0, bit counter=0, baud counter=0, shift register=0.
- FSM states: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If start=1 at edge T0: go to LOAD, ram_addr stays 0, busy=1 from T0.
- LOAD (exactly 1 cycle):
  - At the next edge, shift_reg <= ram_data, tx <= 0, go to START, baud counter cleared.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Then go to DATA with bit index 0; tx <= shift_reg[0].
- DATA:
  - Each bit is held CLKS_PER_BIT cycles, LSB first, shifting right.
  - After the bit-7 period, go to STOP with tx <= 1.
- STOP: tx=1 for CLKS_PER_BIT cycles, then:
  - If ram_addr != 2**ADDR_W-1: ram_addr <= ram_addr+1, go to LOAD.
  - Else: ram_addr <= 0, go to IDLE, busy <= 0, done <= 1 for exactly one cycle.
- Timing:
  - Per word: 1 + 10*CLKS_PER_BIT cycles.
  - tx falls at T0+1.
  - done is high during the cycle after edge T0 + 2**ADDR_W*(1+10*CLKS_PER_BIT).
- Address wrap: ram_addr returns to 0 only on completion. The counter never wraps inside a dump, and no word is sent twice.
- start while busy=1 (any state other than IDLE) is ignored. It is not queued.
- start high during the done cycle: the FSM is already in IDLE, so the start is accepted and a new dump begins next cycle (back-to-back dumps allowed).
- Data stability: the word is frozen in shift_reg at LOAD. RAM writes during START/DATA/STOP do not affect the byte in flight; they are visible only at the next LOAD of that address.
- Baud counter width is clog2(CLKS_PER_BIT); bit index is 3 bits. There is no fractional-baud handling.
- tx is driven from a register (glitch-free); no combinational path from ram_data to tx.

Test Plan:
- Reset: assert rst_n=0 for 3 cycles, then release -> tx=1, busy=0, done=0, ram_addr=0 held for 100 cycles with start=0.
- Full dump, CLKS_PER_BIT=4, RAM model word[a]=a^8'hA5:
  - start pulse at T0 -> 64 frames decoded by the bench UART receiver equal to 8'hA5, 8'hA4, ..., 8'h9A, in address order.
  - done single pulse at T0+64*41, busy low afterwards.
- Frame timing, CLKS_PER_BIT=4, word[0]=8'h01:
  - tx low on cycles T0+1..T0+4.
  - Bit0=1 on T0+5..T0+8, bits1..7=0.
  - Stop high on T0+37..T0+40.
  - ram_addr=1 at T0+41.
- Busy/back-to-back:
  - start pulses at T0+10 and T0+500 are ignored (exactly 64 bytes sent).
  - start held high through the done cycle -> a second dump starts with tx falling 2 cycles after done.
- Reset mid-frame: drop rst_n at T0+20 (inside word 0, DATA) -> tx=1 and busy=0 in the same cycle. After release with start=0, no further tx activity for 200 cycles.
- Write during frame: overwrite word[5] with 8'h00 while word 5 is in DATA -> bench still receives the original word[5]=8'hA0. A second dump returns 8'h00 at position 5.
